// File: rtl/demux4_buffered_if.sv
// Handshake bundle for demux4_buffered: one producer stream,
// four buffered consumer channels and debug counters.
interface demux4_buffered_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic [1:0]       control;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] outA_data;
    logic [WIDTH-1:0] outB_data;
    logic [WIDTH-1:0] outC_data;
    logic [WIDTH-1:0] outD_data;
    logic             outA_valid;
    logic             outB_valid;
    logic             outC_valid;
    logic             outD_valid;
    logic             outA_ready;
    logic             outB_ready;
    logic             outC_ready;
    logic             outD_ready;

    logic [CNT_W-1:0] cntA;
    logic [CNT_W-1:0] cntB;
    logic [CNT_W-1:0] cntC;
    logic [CNT_W-1:0] cntD;

    modport master (
        output control, in_data, in_valid,
        output outA_ready, outB_ready, outC_ready, outD_ready,
        input  in_ready,
        input  outA_data, outB_data, outC_data, outD_data,
        input  outA_valid, outB_valid, outC_valid, outD_valid,
        input  cntA, cntB, cntC, cntD
    );

    modport slave (
        input  control, in_data, in_valid,
        input  outA_ready, outB_ready, outC_ready, outD_ready,
        output in_ready,
        output outA_data, outB_data, outC_data, outD_data,
        output outA_valid, outB_valid, outC_valid, outD_valid,
        output cntA, cntB, cntC, cntD
    );
endinterface

// File: rtl/demux4_buffered.sv
// 1-to-4 registered demux: steers each accepted word into one of
// four single-entry buffers and counts delivered words per channel.
module demux4_buffered #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    demux4_buffered_if.slave  bus
);
    logic [3:0]       v;
    logic [WIDTH-1:0] d   [4];
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       rdy;
    logic             v_sel;
    logic             r_sel;
    logic             acc;

    assign rdy = {bus.outD_ready, bus.outC_ready,
                  bus.outB_ready, bus.outA_ready};

    always_comb begin
        v_sel = 1'b0;
        r_sel = 1'b0;
        case (bus.control)
            2'd0: begin v_sel = v[0]; r_sel = rdy[0]; end
            2'd1: begin v_sel = v[1]; r_sel = rdy[1]; end
            2'd2: begin v_sel = v[2]; r_sel = rdy[2]; end
            2'd3: begin v_sel = v[3]; r_sel = rdy[3]; end
            default: begin v_sel = 1'b0; r_sel = 1'b0; end
        endcase
    end

    // Only the selected channel can stall the producer.
    assign bus.in_ready = rst_n & (~v_sel | r_sel);
    assign acc = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < 4; i++) begin
                d[i]   <= '0;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (acc && bus.control == 2'(i)) begin
                    d[i] <= bus.in_data;
                    v[i] <= 1'b1;
                end else if (v[i] && rdy[i]) begin
                    v[i] <= 1'b0;
                end
                if (v[i] && rdy[i])
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    assign bus.outA_data  = d[0];
    assign bus.outB_data  = d[1];
    assign bus.outC_data  = d[2];
    assign bus.outD_data  = d[3];
    assign bus.outA_valid = v[0];
    assign bus.outB_valid = v[1];
    assign bus.outC_valid = v[2];
    assign bus.outD_valid = v[3];
    assign bus.cntA       = cnt[0];
    assign bus.cntB       = cnt[1];
    assign bus.cntC       = cnt[2];
    assign bus.cntD       = cnt[3];
endmodule

// File: tb/tb_demux4_buffered.sv
// Scoreboard bench for demux4_buffered: per-channel expected-word
// queues and counter model, plus directed handshake checks.
module tb_demux4_buffered;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    demux4_buffered_if #(.WIDTH(32), .CNT_W(8)) bus ();

    demux4_buffered #(.WIDTH(32), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [3:0]  ov;
    logic [3:0]  ordy;
    logic [31:0] od [4];
    logic [7:0]  oc [4];

    assign ov    = {bus.outD_valid, bus.outC_valid,
                    bus.outB_valid, bus.outA_valid};
    assign ordy  = {bus.outD_ready, bus.outC_ready,
                    bus.outB_ready, bus.outA_ready};
    assign od[0] = bus.outA_data;
    assign od[1] = bus.outB_data;
    assign od[2] = bus.outC_data;
    assign od[3] = bus.outD_data;
    assign oc[0] = bus.cntA;
    assign oc[1] = bus.cntB;
    assign oc[2] = bus.cntC;
    assign oc[3] = bus.cntD;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h want %0h at %0t",
                     tag, got, exp, $time);
        else
            n_pass++;
    endtask

    logic [31:0] q [4][$];
    logic [7:0]  mcnt [4];

    // Queues mirror buffer contents; updated for the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                q[i].delete();
                mcnt[i] = 8'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("sb_valid%0d", i), 64'(ov[i]),
                    64'(q[i].size() != 0));
                chk($sformatf("sb_cnt%0d", i), 64'(oc[i]),
                    64'(mcnt[i]));
                if (ov[i] && q[i].size() != 0)
                    chk($sformatf("sb_data%0d", i), 64'(od[i]),
                        64'(q[i][0]));
                if (ov[i] && ordy[i]) begin
                    if (q[i].size() != 0)
                        void'(q[i].pop_front());
                    mcnt[i] = mcnt[i] + 8'd1;
                end
            end
            if (bus.in_valid && bus.in_ready)
                q[bus.control].push_back(bus.in_data);
        end
    end

    task automatic send(input int ch, input logic [31:0] w);
        logic ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.control  = 2'(ch);
        bus.in_data  = w;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = bus.in_ready;
        end
        if (!ok)
            chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk($sformatf("lat%0d", ch), 64'(ov[ch]), 64'd1);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.in_valid   = 1'b1;
        bus.control    = 2'd0;
        bus.in_data    = 32'h5555_5555;
        bus.outA_ready = 1'b0;
        bus.outB_ready = 1'b0;
        bus.outC_ready = 1'b0;
        bus.outD_ready = 1'b0;

        // reset with producer pushing
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("rst_valid", 64'(ov[i]), 64'd0);
            chk("rst_data", 64'(od[i]), 64'd0);
            chk("rst_cnt", 64'(oc[i]), 64'd0);
        end
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;

        // route sweep
        for (int i = 0; i < 4; i++)
            send(i, 32'(i + 1));
        for (int i = 0; i < 4; i++) begin
            chk("sweep_data", 64'(od[i]), 64'(i + 1));
            chk("sweep_cnt", 64'(oc[i]), 64'd0);
        end

        // backpressure on A
        bus.in_valid = 1'b1;
        bus.control  = 2'd0;
        bus.in_data  = 32'h0000_AAAA;
        @(negedge clk);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_hold", 64'(od[0]), 64'd1);
        @(posedge clk);
        #1;
        chk("bp_hold2", 64'(od[0]), 64'd1);
        bus.outA_ready = 1'b1;
        #1;
        chk("bp_release", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        bus.outA_ready = 1'b0;
        chk("bp_data", 64'(bus.outA_data), 64'h0000_AAAA);
        chk("bp_cnt", 64'(bus.cntA), 64'd1);

        // streaming on B
        bus.outB_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = 1'b1;
            bus.control  = 2'd1;
            bus.in_data  = 32'hB000 + 32'(k);
            @(negedge clk);
            chk("stream_rdy", 64'(bus.in_ready), 64'd1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("stream_cnt", 64'(bus.cntB), 64'd10);
        chk("stream_valid", 64'(bus.outB_valid), 64'd1);
        @(posedge clk);
        #1;
        bus.outB_ready = 1'b0;
        chk("stream_cnt2", 64'(bus.cntB), 64'd11);
        chk("stream_empty", 64'(bus.outB_valid), 64'd0);

        // counter wrap on C
        bus.outC_ready = 1'b1;
        for (int k = 0; k < 255; k++) begin
            bus.in_valid = 1'b1;
            bus.control  = 2'd2;
            bus.in_data  = 32'hC000 + 32'(k);
            @(negedge clk);
            chk("wrap_rdy", 64'(bus.in_ready), 64'd1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("wrap_pre", 64'(bus.cntC), 64'd255);
        @(posedge clk);
        #1;
        bus.outC_ready = 1'b0;
        chk("wrap_cntC", 64'(bus.cntC), 64'd0);
        chk("wrap_cntA", 64'(bus.cntA), 64'd1);
        chk("wrap_cntB", 64'(bus.cntB), 64'd11);
        chk("wrap_cntD", 64'(bus.cntD), 64'd0);
        chk("wrap_validC", 64'(bus.outC_valid), 64'd0);

        // reset mid-operation with A and D full
        chk("mid_pre_A", 64'(bus.outA_valid), 64'd1);
        chk("mid_pre_D", 64'(bus.outD_valid), 64'd1);
        rst_n          = 1'b0;
        bus.outA_ready = 1'b1;
        bus.in_valid   = 1'b1;
        bus.control    = 2'd3;
        bus.in_data    = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        bus.outA_ready = 1'b0;
        bus.in_valid   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("mid_valid", 64'(ov[i]), 64'd0);
            chk("mid_cnt", 64'(oc[i]), 64'd0);
            chk("mid_data", 64'(od[i]), 64'd0);
        end
        send(0, 32'h0000_1234);
        chk("mid_after", 64'(bus.outA_data), 64'h0000_1234);
        chk("mid_after_cnt", 64'(bus.cntA), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
